deflate_bit_packer: RTL and testbench

//   Parametrised LSB-first bit packer for the GZIP/DEFLATE compress path. Sits between the Huffman/LZ77 encoder and the output FIFO.
//   It merges variable-length codes (block header, literal/length codes, extra bits) into OUT_WIDTH-bit words and writes them out.

---
 rtl/deflate_bit_packer_pkg.sv | 35 +++
 rtl/deflate_bit_packer_if.sv | 34 +++
 rtl/deflate_bit_packer.sv | 88 ++++++++
 tb/tb_deflate_bit_packer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/deflate_bit_packer_pkg.sv
// Shared types, DEFLATE block codes and width helpers for the LSB-first bit packer.
// Imported by the packer interface and the packer itself.
package deflate_bit_packer_pkg;

   localparam int DEF_OUT_WIDTH    = 32;
   localparam int DEF_MAX_CODE_LEN = 32;

   // Block header fields as they appear in the DEFLATE bit stream
   localparam logic BFINAL_LAST = 1'b1;
   localparam logic BFINAL_MORE = 1'b0;

   typedef enum logic [1:0] {
      BTYPE_STORED  = 2'b00,
      BTYPE_FIXED   = 2'b01,
      BTYPE_DYNAMIC = 2'b10,
      BTYPE_RSVD    = 2'b11
   } btype_e;

   typedef enum logic {
      PACK  = 1'b0,
      DRAIN = 1'b1
   } pk_state_e;

   function automatic int clogb2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int round_up8(input int n);
      return (n + 7) & ~7;
   endfunction

endpackage

// File: rtl/deflate_bit_packer_if.sv
// Code-in / flush / word-out handshake bundle of the bit packer.
// The slave side is the packer; the master side is the encoder plus output FIFO.
interface deflate_bit_packer_if import deflate_bit_packer_pkg::*; #(
   parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
   parameter int MAX_CODE_LEN = DEF_MAX_CODE_LEN
);
   localparam int LEN_W   = clogb2(MAX_CODE_LEN + 1);
   localparam int BYTES_W = clogb2(OUT_WIDTH / 8 + 1);

   logic                    code_valid;
   logic [MAX_CODE_LEN-1:0] code_in;
   logic [LEN_W-1:0]        code_len;
   logic                    code_ready;
   logic                    flush_valid;
   logic                    flush_mode;
   logic                    flush_ready;
   logic                    flush_done;
   logic [OUT_WIDTH-1:0]    dout;
   logic [BYTES_W-1:0]      dout_bytes;
   logic                    dout_last;
   logic                    dout_valid;
   logic                    dout_ready;

   modport master (
      output code_valid, code_in, code_len, flush_valid, flush_mode, dout_ready,
      input  code_ready, flush_ready, flush_done, dout, dout_bytes, dout_last, dout_valid
   );

   modport slave (
      input  code_valid, code_in, code_len, flush_valid, flush_mode, dout_ready,
      output code_ready, flush_ready, flush_done, dout, dout_bytes, dout_last, dout_valid
   );

endinterface

// File: rtl/deflate_bit_packer.sv
// LSB-first bit packer: merges variable-length codes into OUT_WIDTH-bit words,
// with byte-align flush and final flush that tags the partial word with its byte count.
module deflate_bit_packer import deflate_bit_packer_pkg::*; #(
   parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
   parameter int MAX_CODE_LEN = DEF_MAX_CODE_LEN
) (
   input logic                clk,
   input logic                rst_n,
   deflate_bit_packer_if.slave bus
);
   localparam int ACC_W   = OUT_WIDTH + MAX_CODE_LEN;
   localparam int CNT_W   = clogb2(ACC_W + 1);
   localparam int BYTES_W = clogb2(OUT_WIDTH / 8 + 1);
   localparam logic [CNT_W-1:0] OW_C = CNT_W'(OUT_WIDTH);

   pk_state_e               state_q, state_d;
   logic [ACC_W-1:0]        acc_q, acc_d, acc_base;
   logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_base;
   logic                    done_q, done_d;
   logic                    word_rdy, word_xfer, code_xfer, flush_xfer;
   logic [MAX_CODE_LEN-1:0] code_m;

   assign word_rdy   = (state_q == DRAIN) || (cnt_q >= OW_C);
   assign word_xfer  = word_rdy && bus.dout_ready;
   assign code_xfer  = bus.code_valid && bus.code_ready;
   assign flush_xfer = bus.flush_valid && bus.flush_ready;

   assign bus.code_ready  = (state_q == PACK) && ((cnt_q < OW_C) || word_xfer);
   assign bus.flush_ready = (state_q == PACK) && !bus.code_valid && (cnt_q < OW_C);
   assign bus.flush_done  = done_q;

   // Shifting an all-ones field by code_len leaves exactly the bits above the code
   assign code_m = bus.code_in & ~({MAX_CODE_LEN{1'b1}} << bus.code_len);

   assign bus.dout       = acc_q[OUT_WIDTH-1:0];
   assign bus.dout_valid = word_rdy;
   assign bus.dout_last  = (state_q == DRAIN);
   assign bus.dout_bytes = !word_rdy          ? '0 :
                           (state_q == DRAIN) ? BYTES_W'(cnt_q >> 3) :
                                                BYTES_W'(OUT_WIDTH / 8);

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      // A code accepted alongside a word handshake lands after the shift
      acc_base = word_xfer ? (acc_q >> OUT_WIDTH) : acc_q;
      cnt_base = word_xfer ? (cnt_q - OW_C) : cnt_q;
      unique case (state_q)
         PACK: begin
            acc_d = acc_base;
            cnt_d = cnt_base;
            if (code_xfer) begin
               acc_d = acc_base | (ACC_W'(code_m) << cnt_base);
               cnt_d = cnt_base + CNT_W'(bus.code_len);
            end else if (flush_xfer) begin
               cnt_d = CNT_W'(round_up8(int'(cnt_q)));
               if (bus.flush_mode && (cnt_q != '0)) state_d = DRAIN;
               else                                 done_d  = 1'b1;
            end
         end
         DRAIN: begin
            if (word_xfer) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = PACK;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PACK;
         acc_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_deflate_bit_packer.sv
// Bench for deflate_bit_packer: a bit-queue stream model checked every cycle,
// directed literal scenarios, a 64-bit instance and a randomized soak.
module tb_deflate_bit_packer;
   import deflate_bit_packer_pkg::*;

   localparam int OW = 32;
   localparam int ML = 32;

   typedef struct {
      logic [31:0] d;
      int          bytes;
      bit          last;
   } word_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   deflate_bit_packer_if #(.OUT_WIDTH(OW), .MAX_CODE_LEN(ML)) a ();
   deflate_bit_packer_if #(.OUT_WIDTH(64), .MAX_CODE_LEN(ML)) b ();

   deflate_bit_packer #(.OUT_WIDTH(OW), .MAX_CODE_LEN(ML)) dut (
      .clk(clk), .rst_n(rst_n), .bus(a));
   deflate_bit_packer #(.OUT_WIDTH(64), .MAX_CODE_LEN(ML)) dut64 (
      .clk(clk), .rst_n(rst_n), .bus(b));

   int n_chk = 0;
   int n_pass = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endfunction

   // Stream model: the pending bits in emission order
   bit          q[$];
   bit          draining = 0;
   bit          exp_done = 0;
   int          done_seen = 0;
   word_t       got[$];
   logic [63:0] got64[$];
   int          got64_bytes;

   bit          m_ev, m_ecr, m_efr;
   logic [31:0] m_ew;
   int          m_eb, m_n;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         draining = 0;
         exp_done = 0;
      end else begin
         m_ev  = draining || (q.size() >= OW);
         m_ecr = !draining && ((q.size() < OW) || (m_ev && a.dout_ready));
         m_efr = !draining && !a.code_valid && (q.size() < OW);
         m_ew  = '0;
         for (int i = 0; i < OW && i < q.size(); i++) m_ew[i] = q[i];
         m_eb  = draining ? q.size() / 8 : OW / 8;
         chk("dout_valid", a.dout_valid, m_ev);
         chk("code_ready", a.code_ready, m_ecr);
         chk("flush_ready", a.flush_ready, m_efr);
         chk("flush_done", a.flush_done, exp_done);
         if (a.flush_done) done_seen++;
         if (m_ev) begin
            chk("dout", a.dout, m_ew);
            chk("dout_bytes", a.dout_bytes, m_eb);
            chk("dout_last", a.dout_last, draining);
         end
         exp_done = 0;
         if (m_ev && a.dout_ready) begin
            got.push_back('{a.dout, int'(a.dout_bytes), a.dout_last});
            m_n = draining ? q.size() : OW;
            repeat (m_n) void'(q.pop_front());
            if (draining) begin
               draining = 0;
               exp_done = 1;
            end
         end
         if (a.code_valid && m_ecr)
            for (int i = 0; i < int'(a.code_len); i++) q.push_back(a.code_in[i]);
         if (a.flush_valid && m_efr) begin
            while (q.size() % 8 != 0) q.push_back(1'b0);
            if (a.flush_mode && q.size() > 0) draining = 1;
            else                              exp_done = 1;
         end
      end
   end

   always @(negedge clk)
      if (rst_n && b.dout_valid && b.dout_ready) begin
         got64.push_back(b.dout);
         got64_bytes = int'(b.dout_bytes);
      end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_code(input logic [31:0] c, input int len);
      int n;
      n = 0;
      a.code_in = c; a.code_len = 6'(len); a.code_valid = 1'b1;
      @(negedge clk);
      while (!a.code_ready && n < 100) begin @(negedge clk); n++; end
      if (!a.code_ready) chk("code_accept_timeout", a.code_ready, 1);
      @(posedge clk); #1;
      a.code_valid = 1'b0;
   endtask

   task automatic send_flush(input bit mode);
      int n;
      n = 0;
      a.flush_mode = mode; a.flush_valid = 1'b1;
      @(negedge clk);
      while (!a.flush_ready && n < 100) begin @(negedge clk); n++; end
      if (!a.flush_ready) chk("flush_accept_timeout", a.flush_ready, 1);
      @(posedge clk); #1;
      a.flush_valid = 1'b0;
   endtask

   task automatic chk_word(input string nm, input int idx, input logic [31:0] d,
                           input int bytes, input bit last);
      if (got.size() > idx) begin
         chk({nm, "_data"}, got[idx].d, d);
         chk({nm, "_bytes"}, got[idx].bytes, bytes);
         chk({nm, "_last"}, got[idx].last, last);
      end else chk({nm, "_missing"}, got.size(), idx + 1);
   endtask

   int d0;

   initial begin
      a.code_valid = 0; a.code_in = '0; a.code_len = '0;
      a.flush_valid = 0; a.flush_mode = 0; a.dout_ready = 1;
      b.code_valid = 0; b.code_in = '0; b.code_len = '0;
      b.flush_valid = 0; b.flush_mode = 0; b.dout_ready = 1;

      // Reset state
      rst_n = 0;
      repeat (50) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      chk("rst_dout_valid", a.dout_valid, 0);
      chk("rst_code_ready", a.code_ready, 1);
      chk("rst_flush_ready", a.flush_ready, 1);
      chk("rst_dout", a.dout, 0);
      chk("rst_dout_bytes", a.dout_bytes, 0);
      chk("rst_dout_last", a.dout_last, 0);
      chk("rst_flush_done", a.flush_done, 0);
      @(posedge clk); #1;

      // Four bytes make one word
      got.delete();
      send_code(32'h61, 8); send_code(32'h62, 8);
      send_code(32'h63, 8); send_code(32'h64, 8);
      tick(3);
      chk("t2_count", got.size(), 1);
      chk_word("t2_w0", 0, 32'h64636261, 4, 0);

      // Straddling code then final flush of one leftover bit
      got.delete(); d0 = done_seen;
      send_code(32'hFFFF_FFFD, 3);
      send_code(32'h1FFF_FFFF, 30);
      tick(2);
      send_flush(1);
      tick(4);
      chk("t3_count", got.size(), 2);
      chk_word("t3_w0", 0, 32'hFFFF_FFFD, 4, 0);
      chk_word("t3_w1", 1, 32'h0, 1, 1);
      chk("t3_done", done_seen - d0, 1);

      // Align flush pads to a byte; final flush with nothing pending
      got.delete(); d0 = done_seen;
      send_code(32'h1, 3);
      send_flush(0);
      send_code(32'hAB, 8); send_code(32'hAB, 8); send_code(32'hAB, 8);
      tick(3);
      send_flush(1);
      tick(3);
      chk("t4_count", got.size(), 1);
      chk_word("t4_w0", 0, 32'hABAB_AB01, 4, 0);
      chk("t4_done", done_seen - d0, 2);

      // Back-pressure holds the word and blocks codes
      got.delete();
      a.dout_ready = 0;
      send_code(32'h11, 8); send_code(32'h22, 8);
      send_code(32'h33, 8); send_code(32'h44, 8);
      repeat (10) begin
         @(negedge clk);
         chk("t5_stall_code_ready", a.code_ready, 0);
         chk("t5_stall_dout", a.dout, 32'h4433_2211);
      end
      @(posedge clk); #1 a.dout_ready = 1;
      tick(3);
      chk("t5_count", got.size(), 1);
      chk_word("t5_w0", 0, 32'h4433_2211, 4, 0);
      @(negedge clk);
      chk("t5_code_ready", a.code_ready, 1);
      @(posedge clk); #1;

      // Reset mid-pack drops partial bits
      got.delete();
      send_code(32'h3FF, 10); send_code(32'h2AA, 10);
      rst_n = 0;
      tick(2);
      rst_n = 1;
      tick(1);
      d0 = done_seen;
      send_flush(1);
      tick(3);
      chk("t6_count", got.size(), 0);
      chk("t6_done", done_seen - d0, 1);

      // 64-bit instance packs eight bytes into one word
      got64.delete();
      for (int i = 0; i < 8; i++) begin
         b.code_in = 32'h61 + 32'(i); b.code_len = 6'd8; b.code_valid = 1;
         @(negedge clk);
         chk("t6_64_code_ready", b.code_ready, 1);
         @(posedge clk); #1;
      end
      b.code_valid = 0;
      tick(3);
      chk("t6_64_count", got64.size(), 1);
      if (got64.size() > 0) begin
         chk("t6_64_data", got64[0], 64'h6867_6665_6463_6261);
         chk("t6_64_bytes", got64_bytes, 8);
      end

      // Randomized soak against the stream model
      repeat (4000) begin
         a.code_valid  = ($urandom % 3) != 0;
         a.code_len    = 6'($urandom_range(0, 32));
         a.code_in     = $urandom;
         a.flush_valid = ($urandom % 8) == 0;
         a.flush_mode  = $urandom % 2;
         a.dout_ready  = ($urandom % 4) != 0;
         tick(1);
      end
      a.code_valid = 0; a.flush_valid = 0; a.dout_ready = 1;
      tick(5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
